// File: rtl/modulo_mef_contagem_duzias.sv
// Dozen-counting FSM: counts sealed bottles per carton, tracks cork stock, drives eb/ro upstream.
// Optional macro DUZIAS_BCD_EN adds a 3-digit BCD copy of the completed-carton count.
module modulo_mef_contagem_duzias #(
    parameter int unsigned GARRAFAS_POR_CX = 12,
    parameter int unsigned ROLHAS_MAX      = 100,
    parameter int unsigned ROLHAS_RECARGA  = 15,
    parameter int unsigned ROLHAS_INICIAL  = 0,
    parameter int unsigned DUZIAS_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                ve,
    input  logic                cx,
    input  logic                rec,
    output logic                eb,
    output logic                ro,
    output logic                troca_cx,
    output logic                erro,
    output logic [3:0]          garrafas,
    output logic [DUZIAS_W-1:0] duzias,
    output logic [6:0]          rolhas
`ifdef DUZIAS_BCD_EN
    ,
    output logic [11:0]         duzias_bcd
`endif
);

    localparam logic [1:0] ST_SEM_CAIXA = 2'd0;
    localparam logic [1:0] ST_CONTANDO  = 2'd1;
    localparam logic [1:0] ST_CHEIA     = 2'd2;

    localparam logic [3:0] GARRAFAS_FIM = 4'(GARRAFAS_POR_CX);
    localparam logic [7:0] MAX_8        = 8'(ROLHAS_MAX);
    localparam logic [7:0] RECARGA_8    = 8'(ROLHAS_RECARGA);
    localparam logic [6:0] INICIAL_7    = 7'(ROLHAS_INICIAL);

    logic [1:0]          state_q, state_d;
    logic [3:0]          garrafas_q, garrafas_d;
    logic [DUZIAS_W-1:0] duzias_q, duzias_d;
    logic [6:0]          rolhas_q, rolhas_d;
    logic                erro_q, erro_d;
    logic                ve_prev_q, rec_prev_q;

    logic                seal_ev, refill_ev, seal_ok;
    logic [7:0]          rolhas_sum;

    assign seal_ev   = ve & ~ve_prev_q;
    assign refill_ev = rec & ~rec_prev_q;
    assign seal_ok   = enable && seal_ev && (state_q == ST_CONTANDO) && (rolhas_q != '0);

    // Seal and refill fold into one sum; seal_ok guarantees rolhas_q>0 so no underflow.
    assign rolhas_sum = {1'b0, rolhas_q} + (refill_ev ? RECARGA_8 : 8'd0) - {7'd0, seal_ok};

`ifdef DUZIAS_BCD_EN
    logic [11:0] bcd_q, bcd_d;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = (v[11:8] != 4'd9) ? v[11:8] + 4'd1 : 4'd0;
            end
        end
        return r;
    endfunction

    assign duzias_bcd = bcd_q;
`endif

    always_comb begin
        state_d    = state_q;
        garrafas_d = garrafas_q;
        duzias_d   = duzias_q;
        rolhas_d   = rolhas_q;
        erro_d     = erro_q;
`ifdef DUZIAS_BCD_EN
        bcd_d      = bcd_q;
`endif
        if (enable) begin
            if (seal_ev && !seal_ok) begin
                erro_d = 1'b1;
            end
            rolhas_d = (rolhas_sum > MAX_8) ? MAX_8[6:0] : rolhas_sum[6:0];

            case (state_q)
                ST_SEM_CAIXA: begin
                    if (cx) begin
                        state_d    = ST_CONTANDO;
                        garrafas_d = '0;
                    end
                end
                ST_CONTANDO: begin
                    // A counted seal defers any cx=0 exit to the next edge.
                    if (seal_ok) begin
                        garrafas_d = garrafas_q + 4'd1;
                        if (garrafas_q + 4'd1 == GARRAFAS_FIM) begin
                            state_d = ST_CHEIA;
                        end
                    end else if (!cx) begin
                        state_d = ST_SEM_CAIXA;
                    end
                end
                ST_CHEIA: begin
                    if (!cx) begin
                        state_d    = ST_SEM_CAIXA;
                        duzias_d   = duzias_q + 1'b1;
                        garrafas_d = '0;
`ifdef DUZIAS_BCD_EN
                        bcd_d      = bcd_inc(bcd_q);
`endif
                    end
                end
                default: state_d = ST_SEM_CAIXA;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SEM_CAIXA;
            garrafas_q <= '0;
            duzias_q   <= '0;
            rolhas_q   <= INICIAL_7;
            erro_q     <= 1'b0;
            ve_prev_q  <= 1'b0;
            rec_prev_q <= 1'b0;
`ifdef DUZIAS_BCD_EN
            bcd_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            garrafas_q <= garrafas_d;
            duzias_q   <= duzias_d;
            rolhas_q   <= rolhas_d;
            erro_q     <= erro_d;
            ve_prev_q  <= ve;
            rec_prev_q <= rec;
`ifdef DUZIAS_BCD_EN
            bcd_q      <= bcd_d;
`endif
        end
    end

    assign eb       = (state_q != ST_CONTANDO);
    assign troca_cx = (state_q == ST_CHEIA);
    assign ro       = (rolhas_q != '0);
    assign erro     = erro_q;
    assign garrafas = garrafas_q;
    assign duzias   = duzias_q;
    assign rolhas   = rolhas_q;

endmodule

// File: tb/tb_modulo_mef_contagem_duzias.sv
// Directed bench for modulo_mef_contagem_duzias with hand-computed expectations.
module tb_modulo_mef_contagem_duzias;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       ve = 1'b0;
    logic       cx = 1'b0;
    logic       rec = 1'b0;
    logic       eb, ro, troca_cx, erro;
    logic [3:0] garrafas;
    logic [7:0] duzias;
    logic [6:0] rolhas;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    modulo_mef_contagem_duzias #(
        .GARRAFAS_POR_CX(12),
        .ROLHAS_MAX(100),
        .ROLHAS_RECARGA(15),
        .ROLHAS_INICIAL(0),
        .DUZIAS_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .ve(ve),
        .cx(cx),
        .rec(rec),
        .eb(eb),
        .ro(ro),
        .troca_cx(troca_cx),
        .erro(erro),
        .garrafas(garrafas),
        .duzias(duzias),
        .rolhas(rolhas)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic seal_pulse;
        ve = 1'b1; tick;
        ve = 1'b0; tick;
    endtask

    task automatic refill_pulse;
        rec = 1'b1; tick;
        rec = 1'b0; tick;
    endtask

    initial begin
        int unsigned exp_rolhas [7] = '{15, 30, 45, 60, 75, 90, 100};

        // Reset state
        tick; tick;
        check("rst_garrafas", garrafas, 0);
        check("rst_duzias", duzias, 0);
        check("rst_rolhas", rolhas, 0);
        check("rst_eb", eb, 1);
        check("rst_troca", troca_cx, 0);
        check("rst_erro", erro, 0);
        check("rst_ro", ro, 0);
        rst = 1'b0;
        tick;

        // Refill saturation
        for (int i = 0; i < 7; i++) begin
            refill_pulse;
            check($sformatf("refill_%0d", i), rolhas, exp_rolhas[i]);
            if (i == 0) check("refill_ro", ro, 1);
        end
        check("refill_state_eb", eb, 1);

        // Carton cycle
        cx = 1'b1; tick;
        check("cx_in_eb", eb, 0);
        for (int i = 0; i < 12; i++) seal_pulse;
        check("full_garrafas", garrafas, 12);
        check("full_rolhas", rolhas, 88);
        check("full_eb", eb, 1);
        check("full_troca", troca_cx, 1);
        check("full_erro", erro, 0);
        cx = 1'b0; tick;
        check("swap_duzias", duzias, 1);
        check("swap_garrafas", garrafas, 0);
        check("swap_eb", eb, 1);
        check("swap_troca", troca_cx, 0);
        cx = 1'b1; tick;
        check("new_cx_eb", eb, 0);

        // Reset mid-count
        for (int i = 0; i < 5; i++) seal_pulse;
        check("mid_garrafas", garrafas, 5);
        check("mid_rolhas", rolhas, 83);
        rst = 1'b1; tick;
        check("mid_rst_garrafas", garrafas, 0);
        check("mid_rst_duzias", duzias, 0);
        check("mid_rst_rolhas", rolhas, 0);
        check("mid_rst_eb", eb, 1);
        check("mid_rst_troca", troca_cx, 0);
        check("mid_rst_erro", erro, 0);
        rst = 1'b0; tick;
        check("post_rst_eb", eb, 0);

        // Cork exhaustion: 15 -> 12 seals -> 3 -> swap -> 2 seals -> 1
        refill_pulse;
        for (int i = 0; i < 12; i++) seal_pulse;
        check("ex_full_rolhas", rolhas, 3);
        check("ex_full_troca", troca_cx, 1);
        cx = 1'b0; tick;
        cx = 1'b1; tick;
        check("ex_duzias", duzias, 1);
        seal_pulse; seal_pulse;
        check("ex_rolhas1", rolhas, 1);
        check("ex_garrafas2", garrafas, 2);
        seal_pulse;
        check("ex_rolhas0", rolhas, 0);
        check("ex_ro0", ro, 0);
        check("ex_garrafas3", garrafas, 3);
        check("ex_erro_before", erro, 0);
        seal_pulse;
        check("ex_erro_after", erro, 1);
        check("ex_garrafas_hold", garrafas, 3);
        check("ex_rolhas_hold", rolhas, 0);

        // Simultaneous seal and refill at 90
        for (int i = 0; i < 6; i++) refill_pulse;
        check("sim_pre_rolhas", rolhas, 90);
        ve = 1'b1; rec = 1'b1; tick;
        check("sim_rolhas", rolhas, 100);
        check("sim_garrafas", garrafas, 4);
        ve = 1'b0; rec = 1'b0; tick;

        // Held ve counts once
        ve = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        check("held_garrafas", garrafas, 5);
        check("held_rolhas", rolhas, 99);
        ve = 1'b0; tick;

        // Enable freeze: events discarded, no spurious edge on re-enable
        enable = 1'b0;
        for (int i = 0; i < 3; i++) seal_pulse;
        refill_pulse;
        check("frz_garrafas", garrafas, 5);
        check("frz_rolhas", rolhas, 99);
        ve = 1'b1; tick;
        enable = 1'b1; tick;
        check("reen_garrafas", garrafas, 5);
        check("reen_rolhas", rolhas, 99);
        ve = 1'b0; tick;

        // cx removed mid-carton: partial carton lost, garrafas held
        cx = 1'b0; tick;
        check("lost_eb", eb, 1);
        check("lost_garrafas", garrafas, 5);
        check("lost_duzias", duzias, 1);
        check("erro_sticky", erro, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/modulo_mef_contagem_duzias.md
Name: modulo_mef_contagem_duzias

Overview:
- Downstream stage of the filling/sealing FSM on the bottling line.
- Counts sealed bottles into cartons of a dozen and manages carton swaps.
- Tracks the cork (rolha) stock. Drives `ro` (cork available) and `eb` (conveyor blocked) back into the filling/sealing FSM.
- Same clock domain as the filling/sealing FSM; its `ve` output feeds this block directly, so no synchronisers are used.

Parameters:
- GARRAFAS_POR_CX, 12, bottles per carton; terminal value of bottle counter
- ROLHAS_MAX, 100, cork stock saturation ceiling
- ROLHAS_RECARGA, 15, corks added per refill event
- ROLHAS_INICIAL, 0, cork stock after reset
- DUZIAS_W, 8, width of completed-dozen counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  high = block operates; low = freeze
- ve  in  1  seal strobe (level) from the filling/sealing FSM
- cx  in  1  carton-present sensor, 1 = carton in place
- rec  in  1  cork refill button (level, edge-detected)
- eb  out  1  conveyor blocked, to the filling/sealing FSM
- ro  out  1  cork available = (rolhas != 0)
- troca_cx  out  1  request operator to swap the full carton
- erro  out  1  sticky error flag
- garrafas  out  4  bottles in current carton, 0..GARRAFAS_POR_CX
- duzias  out  DUZIAS_W  completed cartons
- rolhas  out  7  cork stock, 0..ROLHAS_MAX

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=SEM_CAIXA, garrafas=0, duzias=0, rolhas=ROLHAS_INICIAL, erro=0. Edge registers ve_d=0, rec_d=0. Therefore eb=1, troca_cx=0, ro=(ROLHAS_INICIAL!=0).
- Reset mid-operation discards all counts immediately.
- Edge detection:
  - seal event = ve & ~ve_d.
  - refill event = rec & ~rec_d.
  - ve_d and rec_d update every cycle, including while enable=0, so re-enabling never produces a spurious edge.
- Latency: an event sampled at clock edge k updates counters/state at edge k; the result is visible after edge k. All outputs are registered or decoded from registers only; there are no combinational paths from inputs.
- enable=0: state, garrafas, duzias, rolhas and erro hold; events are discarded, not queued.
- FSM, state SEM_CAIXA:
  - Outputs: eb=1, troca_cx=0.
  - cx=1 → CONTANDO, with garrafas:=0.
- FSM, state CONTANDO:
  - Outputs: eb=0, troca_cx=0.
  - Valid seal (rolhas!=0): garrafas+1, rolhas-1.
  - If garrafas reaches GARRAFAS_POR_CX → CHEIA in the same edge.
  - cx=0 with no valid seal → SEM_CAIXA; garrafas holds (partial carton lost, not counted).
  - If a valid seal and cx=0 coincide, the seal is counted first, then the cx=0 transition is applied on the following edge.
- FSM, state CHEIA:
  - Outputs: eb=1, troca_cx=1.
  - cx=0 → SEM_CAIXA; duzias+1, wrapping modulo 2^DUZIAS_W; garrafas:=0.
- Invalid seal: a seal event in SEM_CAIXA or CHEIA, or with rolhas=0, is ignored and sets erro=1. erro clears only by reset.
- Cork arithmetic:
  - Refill: rolhas := min(rolhas + ROLHAS_RECARGA, ROLHAS_MAX).
  - Simultaneous valid seal and refill: rolhas := min(rolhas - 1 + ROLHAS_RECARGA, ROLHAS_MAX).
  - Refill is accepted in every state when enable=1.
  - rolhas never underflows below 0.
- ro=1 exactly when rolhas!=0. At rolhas=0 the filling/sealing FSM raises its cork alarm; this block keeps counting nothing until refilled.

Optional Feature:
- Macro: DUZIAS_BCD_EN.
- Defined:
  - Adds output `duzias_bcd` (out, 12 bits): a 3-digit BCD count of completed cartons.
  - Incremented on the same edge as duzias. Per-digit carry 9→0; 999→000. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset state: rst pulse mid-count (garrafas=5) → next cycle garrafas=0, duzias=0, rolhas=ROLHAS_INICIAL, eb=1, troca_cx=0, erro=0.
- Refill saturation: rec pulsed 7 times with ROLHAS_INICIAL=0 → rolhas 15,30,…,90,100; ro=1 after the first pulse.
- Carton cycle: cx=1, rolhas=100, 12 one-cycle ve pulses → garrafas=12, rolhas=88, eb=1, troca_cx=1. Then cx=0 → duzias=1, garrafas=0, eb=1. Then cx=1 → eb=0.
- Cork exhaustion: rolhas=1 with 2 seal pulses → first counted (rolhas=0, ro=0), second ignored; erro=1, garrafas unchanged.
- Simultaneous events: seal edge and refill edge in the same cycle at rolhas=90 → rolhas=100. Separately, ve held high for 10 cycles → counts exactly 1.
- enable freeze: enable=0 with ve pulsed 3 times → garrafas unchanged; enable=1 while ve is still high → no count.
